// File: rtl/sprite_loader_if.sv
// Sprite loader bus: load request, host byte stream, and sprite memory
// write port, plus status. master = host side, slave = the loader.
interface sprite_loader_if #(
  parameter int ADDR_W = 18
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [4:0]        wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, length, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, base_addr, length, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/sprite_loader.sv
// Sprite loader: streams host bytes into sprite memory as 5-bit palette
// indices starting at base_addr for length pixels.
// Optional run-length decoding is enabled by defining SPRITE_LOADER_RLE_EN;
// the default build writes exactly one pixel per accepted byte.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after DONE
// LOAD  | in_ready high, each accepted byte writes one pixel
// RUN   | RLE only: repeating the last index, in_ready low
// DONE  | single cycle after the final write or a rejected request
module sprite_loader #(
  parameter int                ADDR_W    = 18,
  parameter logic [ADDR_W-1:0] MEM_DEPTH = 18'd174080
) (
  input logic            clk,
  input logic            reset,
  sprite_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   end_addr;
  logic              last_px;

`ifdef SPRITE_LOADER_RLE_EN
  logic [2:0]        run_left;
  logic [4:0]        run_data;
`else
  logic              unused_run_field;
  assign unused_run_field = ^bus.in_data[7:5];
`endif

  // Request range check is done one bit wider so base+length cannot wrap.
  assign end_addr = {1'b0, bus.base_addr} + {1'b0, bus.length};
  // The pixel being written this cycle is the last one of the load.
  assign last_px  = (ADDR_W'(cnt + 1'b1) == len_q);

  // Load sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      cnt          <= '0;
      ptr          <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
`ifdef SPRITE_LOADER_RLE_EN
      run_left     <= '0;
      run_data     <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q    <= bus.length;
            ptr      <= bus.base_addr;
            cnt      <= '0;
            bus.err  <= 1'b0;
            bus.busy <= 1'b1;
            if (bus.length == '0) begin
              state <= DONE;
            end else if (end_addr > {1'b0, MEM_DEPTH}) begin
              bus.err <= 1'b1;
              state   <= DONE;
            end else begin
              state        <= LOAD;
              bus.in_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (bus.in_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ptr;
            bus.wr_data <= bus.in_data[4:0];
            ptr         <= ptr + 1'b1;
            cnt         <= cnt + 1'b1;
            if (last_px) begin
              state        <= DONE;
              bus.in_ready <= 1'b0;
`ifdef SPRITE_LOADER_RLE_EN
              // A run that still wanted more pixels was cut short.
              bus.err      <= (bus.in_data[7:5] != 3'd0);
            end else if (bus.in_data[7:5] != 3'd0) begin
              // First pixel of the run is written now; run_left counts the rest.
              state        <= RUN;
              bus.in_ready <= 1'b0;
              run_left     <= bus.in_data[7:5];
              run_data     <= bus.in_data[4:0];
`endif
            end
          end
        end

        RUN: begin
`ifdef SPRITE_LOADER_RLE_EN
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= ptr;
          bus.wr_data <= run_data;
          ptr         <= ptr + 1'b1;
          cnt         <= cnt + 1'b1;
          if (last_px) begin
            state   <= DONE;
            bus.err <= (run_left != 3'd1);
          end else if (run_left == 3'd1) begin
            state        <= LOAD;
            bus.in_ready <= 1'b1;
          end else begin
            run_left <= run_left - 1'b1;
          end
`else
          // Unreachable without RLE; recover to idle if ever entered.
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.in_ready <= 1'b0;
`endif
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end

        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
